// File: rtl/latch_bank_pkg.sv
// Shared types and default sizing for the arbitrated register bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package latch_bank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int NREG_DEF = 8;
  localparam int DW_DEF   = 16;
  localparam int AW_DEF   = 3;

endpackage

// File: rtl/latch_bank_arb_if.sv
// Bundle of requester, clear-control and bank-readout signals.
// Latency: n/a (wiring only).
// Backpressure: req/addr/wdata are held by the master until its ack bit pulses.
interface latch_bank_arb_if
  import latch_bank_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF
);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic               clr;
  logic [NREQ-1:0]    ack;
  logic               busy;
  logic               done;
  logic [NREG*DW-1:0] q;

  modport master (output req, addr, wdata, clr, input ack, busy, done, q);
  modport slave  (input req, addr, wdata, clr, output ack, busy, done, q);

endinterface

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set req bit at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; vld low when no request is pending.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            vld,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx
);

  // Scan candidates in priority order starting at ptr; the first hit wins.
  always_comb begin
    int cand;
    cand   = 0;
    vld    = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!vld && req[cand]) begin
        vld          = 1'b1;
        onehot[cand] = 1'b1;
        idx          = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/latch_bank_arb.sv
// Register bank shared by NREQ writers via round-robin, plus a one-per-cycle bank clear.
// Latency: one cycle from sampled req to committed write and ack; a clear takes NREG cycles.
// Backpressure: requests wait (held by the requester) while another wins or a clear runs.
module latch_bank_arb
  import latch_bank_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic           clk,
  input  logic           resl,
  latch_bank_arb_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [NREQ-1:0] ack_q, ack_nxt;

  logic            we;
  logic [AW-1:0]   wa;
  logic [DW-1:0]   wd;
  logic [NREG-1:0] en;
  logic [DW-1:0]   bank [NREG];

  logic            pick_vld;
  logic [NREQ-1:0] pick_oh;
  logic [PW-1:0]   pick_idx;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .vld    (pick_vld),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  // Next-state, write port and ack selection; clr pre-empts any grant in IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    ack_nxt   = '0;
    we        = 1'b0;
    wa        = cnt;
    wd        = '0;
    case (state)
      IDLE: begin
        if (bus.clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end else if (pick_vld) begin
          we      = 1'b1;
          wa      = bus.addr[pick_idx*AW +: AW];
          wd      = bus.wdata[pick_idx*DW +: DW];
          ack_nxt = pick_oh;
          ptr_nxt = (int'(pick_idx) == NREQ-1) ? '0 : pick_idx + PW'(1);
        end
      end
      CLEAR: begin
        we      = 1'b1;
        wa      = cnt;
        wd      = '0;
        cnt_nxt = cnt + AW'(1);
        if (cnt == AW'(NREG-1)) state_nxt = IDLE;
      end
    endcase
  end

  // Control state register with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (!resl) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= '0;
      ack_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      ack_q <= ack_nxt;
    end
  end

  // Single-port write decode into one enable strobe per register.
  always_comb begin
    en = '0;
    if (we) en[wa] = 1'b1;
  end

  // Mux-hold storage: load on enable, otherwise keep; reset zeroes the bank.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (!resl)      bank[r] <= '0;
      else if (en[r]) bank[r] <= wd;
    end
  end

  for (genvar r = 0; r < NREG; r++) begin : g_q
    assign bus.q[r*DW +: DW] = bank[r];
  end

  assign bus.ack  = ack_q;
  assign bus.busy = (state == CLEAR);
  assign bus.done = (state == CLEAR) && (cnt == AW'(NREG-1));

endmodule

// File: tb/tb_latch_bank_arb.sv
// Bench for latch_bank_arb: directed scenarios plus randomized traffic against a bank model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: requesters hold req until ack, may drop early, may re-request in the ack cycle.
module tb_latch_bank_arb;

  localparam int NREQ = 4;
  localparam int NREG = 8;
  localparam int DW   = 16;
  localparam int AW   = 3;

  logic clk = 1'b0;
  logic resl;

  latch_bank_arb_if #(.NREQ(NREQ), .NREG(NREG), .DW(DW), .AW(AW)) bus ();

  latch_bank_arb #(.NREQ(NREQ), .NREG(NREG), .DW(DW), .AW(AW)) dut (
    .clk  (clk),
    .resl (resl),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: bank contents, rotation pointer, remaining clear cycles, expected ack.
  logic [DW-1:0]   mq [NREG];
  int              mptr;
  int              mleft;
  logic [NREQ-1:0] mack;

  task automatic model_step();
    if (!resl) begin
      for (int r = 0; r < NREG; r++) mq[r] = '0;
      mptr  = 0;
      mleft = 0;
      mack  = '0;
    end else if (mleft > 0) begin
      mq[NREG - mleft] = '0;
      mleft = mleft - 1;
      mack  = '0;
    end else if (bus.clr) begin
      mleft = NREG;
      mack  = '0;
    end else begin
      mack = '0;
      for (int k = 0; k < NREQ; k++) begin
        int w;
        w = (mptr + k) % NREQ;
        if (mack == '0 && bus.req[w]) begin
          mq[bus.addr[w*AW +: AW]] = bus.wdata[w*DW +: DW];
          mack[w] = 1'b1;
          mptr    = (w + 1) % NREQ;
        end
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NREG*DW-1:0] mflat();
    logic [NREG*DW-1:0] f;
    for (int r = 0; r < NREG; r++) f[r*DW +: DW] = mq[r];
    return f;
  endfunction

  function automatic logic [DW-1:0] dq(int r);
    return bus.q[r*DW +: DW];
  endfunction

  task automatic test_reset();
    resl = 1'b0;
    cyc();
    cyc();
    checks++; if (bus.ack !== '0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bus.ack); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.q !== '0) begin failures++; $display("FAIL reset_q got=%h exp=0", bus.q); end
    resl = 1'b1;
  endtask

  task automatic test_single_write();
    logic [NREG*DW-1:0] e;
    e = '0;
    e[3*DW +: DW] = 16'hBEEF;
    bus.req = 4'b0001;
    bus.addr[0 +: AW] = 3'd3;
    bus.wdata[0 +: DW] = 16'hBEEF;
    cyc();
    bus.req = '0;
    checks++; if (bus.ack !== 4'b0001) begin failures++; $display("FAIL single_ack got=%b exp=0001", bus.ack); end
    checks++; if (bus.q !== e) begin failures++; $display("FAIL single_q got=%h exp=%h", bus.q, e); end
    cyc();
    checks++; if (bus.ack !== 4'b0000) begin failures++; $display("FAIL single_ack_drop got=%b exp=0000", bus.ack); end
    checks++; if (bus.q !== e) begin failures++; $display("FAIL single_hold got=%h exp=%h", bus.q, e); end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0]   d [NREQ];
    logic [NREQ-1:0] e;
    resl = 1'b0;
    cyc();
    resl = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      d[i] = DW'($urandom);
      bus.addr[i*AW +: AW]  = AW'(4 + i);
      bus.wdata[i*DW +: DW] = d[i];
    end
    bus.req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      cyc();
      e = NREQ'(1) << (c % NREQ);
      checks++; if (bus.ack !== e) begin failures++; $display("FAIL rr_ack[%0d] got=%b exp=%b", c, bus.ack, e); end
    end
    bus.req = '0;
    for (int i = 0; i < NREQ; i++) begin
      checks++; if (dq(4 + i) !== d[i]) begin failures++; $display("FAIL rr_reg%0d got=%h exp=%h", 4 + i, dq(4 + i), d[i]); end
    end
    cyc();
  endtask

  task automatic test_clear_with_req();
    logic [DW-1:0] w;
    w = DW'($urandom) | 16'h0001;
    bus.clr = 1'b1;
    bus.req = 4'b0010;
    bus.addr[1*AW +: AW]  = 3'd2;
    bus.wdata[1*DW +: DW] = w;
    cyc();
    bus.clr = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL clr_busy[%0d] got=%b exp=1", i, bus.busy); end
      checks++; if (bus.done !== (i == NREG-1)) begin failures++; $display("FAIL clr_done[%0d] got=%b exp=%b", i, bus.done, (i == NREG-1)); end
      checks++; if (bus.ack !== '0) begin failures++; $display("FAIL clr_ack[%0d] got=%b exp=0", i, bus.ack); end
      checks++; if (bus.q !== mflat()) begin failures++; $display("FAIL clr_q[%0d] got=%h exp=%h", i, bus.q, mflat()); end
      if (i > 0) begin
        checks++; if (dq(i - 1) !== '0) begin failures++; $display("FAIL clr_zero[%0d] got=%h exp=0", i - 1, dq(i - 1)); end
      end
      cyc();
    end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL clr_end busy=%b done=%b exp=0,0", bus.busy, bus.done); end
    checks++; if (bus.q !== '0) begin failures++; $display("FAIL clr_all_zero got=%h exp=0", bus.q); end
    checks++; if (bus.ack !== '0) begin failures++; $display("FAIL clr_idle_ack got=%b exp=0", bus.ack); end
    cyc();
    bus.req = '0;
    checks++; if (bus.ack !== 4'b0010) begin failures++; $display("FAIL clr_late_ack got=%b exp=0010", bus.ack); end
    checks++; if (dq(2) !== w) begin failures++; $display("FAIL clr_late_wr got=%h exp=%h", dq(2), w); end
    cyc();
  endtask

  task automatic test_reset_mid_clear();
    bus.req = 4'b0001;
    bus.addr[0 +: AW]  = 3'd5;
    bus.wdata[0 +: DW] = 16'h1234;
    cyc();
    bus.req = '0;
    bus.clr = 1'b1;
    cyc();
    bus.clr = 1'b0;
    cyc();
    cyc();
    resl = 1'b0;
    cyc();
    resl = 1'b1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    checks++; if (bus.q !== '0) begin failures++; $display("FAIL midrst_q got=%h exp=0", bus.q); end
    bus.req = 4'b1111;
    cyc();
    bus.req = '0;
    checks++; if (bus.ack !== 4'b0001) begin failures++; $display("FAIL midrst_ptr got=%b exp=0001", bus.ack); end
    cyc();
  endtask

  task automatic test_same_addr();
    logic [DW-1:0] a, b;
    a = DW'($urandom);
    b = ~a;
    resl = 1'b0;
    cyc();
    resl = 1'b1;
    bus.addr[0 +: AW]  = 3'd6;
    bus.addr[AW +: AW] = 3'd6;
    bus.wdata[0 +: DW]  = a;
    bus.wdata[DW +: DW] = b;
    bus.req = 4'b0011;
    cyc();
    bus.req = 4'b0010;
    checks++; if (bus.ack !== 4'b0001) begin failures++; $display("FAIL same_ack0 got=%b exp=0001", bus.ack); end
    checks++; if (dq(6) !== a) begin failures++; $display("FAIL same_first got=%h exp=%h", dq(6), a); end
    cyc();
    bus.req = '0;
    checks++; if (bus.ack !== 4'b0010) begin failures++; $display("FAIL same_ack1 got=%b exp=0010", bus.ack); end
    cyc();
    checks++; if (dq(6) !== b) begin failures++; $display("FAIL same_final got=%h exp=%h", dq(6), b); end
  endtask

  task automatic test_drop_during_clear();
    bus.clr = 1'b1;
    cyc();
    bus.clr = 1'b0;
    bus.req = 4'b0100;
    bus.addr[2*AW +: AW]  = 3'd1;
    bus.wdata[2*DW +: DW] = 16'hA5A5;
    cyc();
    cyc();
    bus.req = '0;
    for (int n = 0; n < 20 && bus.busy; n++) begin
      cyc();
      checks++; if (bus.ack !== '0) begin failures++; $display("FAIL drop_ack[%0d] got=%b exp=0", n, bus.ack); end
    end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL drop_timeout busy=%b exp=0", bus.busy); end
    cyc();
    checks++; if (bus.ack !== '0) begin failures++; $display("FAIL drop_after got=%b exp=0", bus.ack); end
    checks++; if (dq(1) !== '0) begin failures++; $display("FAIL drop_reg got=%h exp=0", dq(1)); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      resl    = ($urandom_range(0, 49) != 0);
      bus.clr = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i] && bus.ack[i]) begin
          if ($urandom_range(0, 1) == 0) begin
            bus.req[i] = 1'b0;
          end else begin
            bus.addr[i*AW +: AW]  = AW'($urandom);
            bus.wdata[i*DW +: DW] = DW'($urandom);
          end
        end else if (bus.req[i]) begin
          if ($urandom_range(0, 9) == 0) bus.req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          bus.req[i] = 1'b1;
          bus.addr[i*AW +: AW]  = AW'($urandom);
          bus.wdata[i*DW +: DW] = DW'($urandom);
        end
      end
      cyc();
      checks++; if (bus.ack !== mack) begin failures++; $display("FAIL rand_ack[%0d] got=%b exp=%b", n, bus.ack, mack); end
      checks++; if (bus.busy !== (mleft > 0)) begin failures++; $display("FAIL rand_busy[%0d] got=%b exp=%b", n, bus.busy, (mleft > 0)); end
      checks++; if (bus.done !== (mleft == 1)) begin failures++; $display("FAIL rand_done[%0d] got=%b exp=%b", n, bus.done, (mleft == 1)); end
      checks++; if (bus.q !== mflat()) begin failures++; $display("FAIL rand_q[%0d] got=%h exp=%h", n, bus.q, mflat()); end
    end
    resl    = 1'b1;
    bus.clr = 1'b0;
    bus.req = '0;
    cyc();
  endtask

  initial begin
    resl      = 1'b0;
    bus.req   = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.clr   = 1'b0;
    mptr  = 0;
    mleft = 0;
    mack  = '0;
    for (int r = 0; r < NREG; r++) mq[r] = '0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_clear_with_req();
    test_reset_mid_clear();
    test_same_addr();
    test_drop_during_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/latch_bank_arb.md
Name: latch_bank_arb

Overview:
- Shares one bank of NREG enable-loaded, synchronously cleared storage registers between NREQ write requesters.
- Each register slice is a mux-hold flop: it holds its value, or loads on its write enable, and goes to zero when resl is low.
- The block has a round-robin arbiter that picks one writer per cycle, decodes its address into a single enable strobe, and returns a one-cycle ack.
- It also runs a bank-clear sequencer that zeroes the registers one per cycle. It sits between Tom-side control sources and the configuration registers they share.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NREG, 8, number of registers in the bank (power of 2)
- DW, 16, register data width
- AW, 3, address width, equal to log2(NREG)

Ports:
- clk  in  1  system clock; every flop uses its rising edge
- resl  in  1  reset, synchronous and active-low
- req  in  NREQ  write request per requester; held until ack
- addr  in  NREQ*AW  register address per requester; slice i is bits [i*AW +: AW]
- wdata  in  NREQ*DW  write data per requester; slice i is bits [i*DW +: DW]
- clr  in  1  single-cycle pulse that starts a bank clear
- ack  out  NREQ  one-hot, one cycle long: the requester's write has been committed
- busy  out  1  high while a clear is in progress
- done  out  1  one-cycle pulse when a clear completes
- q  out  NREG*DW  contents of the bank; register r is bits [r*DW +: DW]

Behaviour:
- Reset: when resl is low at a clock edge, the following are all cleared, and this overrides every other input in that cycle:
  - all q registers go to 0
  - ack goes to 0, done goes to 0, busy goes to 0
  - state goes to IDLE
  - the round-robin pointer goes to 0
  - the clear counter goes to 0
- Reset mid-clear aborts the clear without a done pulse.
- The state machine has two states, IDLE and CLEAR.
- IDLE, clr low:
  - The winner is the first requester with req high, searching from ptr upward and wrapping modulo NREQ.
  - At the next edge, reg[addr[winner]] loads wdata[winner] and ack[winner] goes high for exactly one cycle.
  - ptr becomes (winner+1) mod NREQ.
  - Latency is one cycle from a sampled req to the committed write plus ack.
  - If no req is high: no write, ptr unchanged, ack all 0.
- IDLE, clr high:
  - Enter CLEAR, with counter cnt = 0.
  - Any request in the same cycle is not granted (clr wins), is not acked, and waits.
- CLEAR:
  - Each cycle reg[cnt] loads 0 and cnt increments.
  - When cnt = NREG-1, that register is written, done pulses for one cycle, and the state returns to IDLE.
  - A clear takes exactly NREG cycles; busy is high for all of them.
  - clr is ignored in CLEAR. No request is granted, ack stays 0, ptr is frozen.
- Handshake:
  - The requester holds req, addr and wdata stable until it sees ack.
  - req still high in the ack cycle is a new request. Because ptr has already advanced, other requesters win first.
  - Dropping req before ack withdraws the request; no write occurs for it.
- Per-cycle limits: at most one register write per cycle and at most one ack bit high.
- Unselected registers hold their value (mux-hold).
- Arithmetic: ptr and cnt wrap modulo NREQ and NREG respectively. Addresses are always in range because NREG = 2^AW.

Decomposition:
- Shared package, latch_bank_pkg, containing:
  - the state enum (IDLE=0, CLEAR=1)
  - default constants for NREQ, NREG, DW, AW
- One sub-module, rr_pick: a combinational round-robin priority picker.
  - Inputs: req vector and ptr.
  - Outputs: valid and a one-hot plus encoded winner.
- The top level instantiates rr_pick and contains the FSM, the counter, the enable decode and the storage.

Test Plan:
- Reset, then req=4'b0001, addr0=3, wdata0=16'hBEEF -> next cycle ack=4'b0001 and reg3=16'hBEEF; all other registers stay 0.
- req=4'b1111 held continuously with distinct addresses, ptr=0 -> ack order is 0,1,2,3,0 on consecutive cycles; each register holds its requester's data.
- clr and req=4'b0010 in the same cycle -> busy high for 8 cycles, registers zeroed 0..7 in order, done pulses in the 8th cycle, ack[1] asserts in the cycle after the return to IDLE.
- resl low in the 3rd cycle of a clear -> next cycle state=IDLE, busy=0, no done pulse, all q=0, ptr=0.
- Two requesters with the same address, req=4'b0011 -> requester 0 is written first, then requester 1 overwrites in the next cycle; the final register value is wdata1.
- req dropped before ack while clear is busy -> no write occurs and ack stays 0.
